// File: rtl/alu_pkg.sv
// Shared ALU opcodes, arbiter FSM states and the flag bundle returned by the external ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic carry;
  } flags_t;

endpackage

// File: rtl/alu_rr_arb.sv
// Two-requester arbiter producing a one-hot grant. Round-robin when ALU_ARBITER_RR_EN
// is defined, otherwise fixed priority with requester 0 winning contention.
module alu_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

`ifdef ALU_ARBITER_RR_EN
  // Remembers who was granted last; reset value makes requester 0 win first.
  logic r_last;

  always_ff @(posedge clk) begin
    if (!rst_n)         r_last <= 1'b1;
    else if (i_advance) r_last <= o_grant[1];
  end

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) o_grant = r_last ? 2'b01 : 2'b10;
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst_n, i_advance};

  always_comb begin
    o_grant = 2'b00;
    if (i_req[0])      o_grant = 2'b01;
    else if (i_req[1]) o_grant = 2'b10;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: IDLE accepts, EXEC drives the ALU,
// RESP holds the result until taken. Arbitration mode selected by ALU_ARBITER_RR_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [5:0]            req_op,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*DATA_W-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_W-1:0]     rsp_res,
  output logic [2:0]            rsp_flags,
  output logic                  busy,
  output logic [2:0]            alu_fnselec,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [DATA_W-1:0]     alu_res,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  input  logic                  alu_carry
);

  state_t              r_state, w_next;
  logic [1:0]          w_grant;
  logic                w_accept, w_capture;
  logic                r_id;
  logic [2:0]          r_op;
  logic [DATA_W-1:0]   r_a, r_b, r_res;
  flags_t              r_flags;
  logic [2:0]          w_op;
  logic [DATA_W-1:0]   w_a, w_b;

  alu_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req_valid),
    .i_advance (w_accept),
    .o_grant   (w_grant)
  );

  assign w_op = w_grant[1] ? req_op[5:3]            : req_op[2:0];
  assign w_a  = w_grant[1] ? req_a[DATA_W +: DATA_W] : req_a[0 +: DATA_W];
  assign w_b  = w_grant[1] ? req_b[DATA_W +: DATA_W] : req_b[0 +: DATA_W];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Grants are only exposed in IDLE and never while reset is asserted.
  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = rst_n ? w_grant : 2'b00;
        if (|(req_valid & req_ready)) begin
          w_accept = 1'b1;
          w_next   = EXEC;
        end
      end
      EXEC: begin
        w_capture = 1'b1;
        w_next    = RESP;
      end
      RESP: begin
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id    <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_flags <= '0;
    end else begin
      if (w_accept) begin
        r_id <= w_grant[1];
        r_op <= w_op;
        r_a  <= w_a;
        r_b  <= w_b;
      end
      if (w_capture) begin
        r_res   <= alu_res;
        r_flags <= '{zero: alu_zero, overflow: alu_overflow, carry: alu_carry};
      end
    end
  end

  assign rsp_valid   = (r_state == RESP);
  assign busy        = (r_state != IDLE);
  assign rsp_id      = r_id;
  assign rsp_res     = r_res;
  assign rsp_flags   = r_flags;
  assign alu_fnselec = r_op;
  assign alu_a       = r_a;
  assign alu_b       = r_b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU standing in for the external one.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req_valid, req_ready;
  logic [5:0]     req_op;
  logic [2*W-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]   rsp_res;
  logic [2:0]     rsp_flags;
  logic           busy;
  logic [2:0]     alu_fnselec;
  logic [W-1:0]   alu_a, alu_b, alu_res;
  logic           alu_zero, alu_overflow, alu_carry;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
    .busy(busy), .alu_fnselec(alu_fnselec), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // External ALU: ADD/SUB report carry/borrow and signed overflow, logic ops clear them.
  logic [W:0] m_s;
  always_comb begin
    m_s = '0; alu_res = '0; alu_carry = 1'b0; alu_overflow = 1'b0;
    case (alu_fnselec)
      OP_ADD: begin
        m_s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res = m_s[W-1:0]; alu_carry = m_s[W];
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (m_s[W-1] != alu_a[W-1]);
      end
      OP_SUB: begin
        m_s = {1'b0, alu_a} - {1'b0, alu_b};
        alu_res = m_s[W-1:0]; alu_carry = m_s[W];
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (m_s[W-1] != alu_a[W-1]);
      end
      OP_NOT: alu_res = ~alu_a;
      OP_AND: alu_res = alu_a & alu_b;
      OP_OR:  alu_res = alu_a | alu_b;
      OP_XOR: alu_res = alu_a ^ alu_b;
      OP_LT:  alu_res = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_res = {{(W-1){1'b0}}, (alu_a == alu_b)};
    endcase
    alu_zero = (alu_res == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req_op = 6'b101_011; req_a = 8'h5C; req_b = 8'h3A;
    tick(); tick();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if ({rsp_valid, busy, rsp_id} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {rsp_valid, busy, rsp_id}); end
    checks++; if ({rsp_res, rsp_flags} !== 7'd0) begin errors++; $display("FAIL reset_rsp: got %h expected 0", {rsp_res, rsp_flags}); end
    checks++; if ({alu_fnselec, alu_a, alu_b} !== 11'd0) begin errors++; $display("FAIL reset_latched: got %h expected 0", {alu_fnselec, alu_a, alu_b}); end
    req_valid = 2'b00; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_op();
    req_op = {OP_XOR, OP_ADD}; req_a = {4'd0, 4'd3}; req_b = {4'd0, 4'd4};
    req_valid = 2'b01; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if ({busy, req_ready, rsp_valid} !== 4'b1000) begin errors++; $display("FAIL single_exec_ctrl: got %b expected 1000", {busy, req_ready, rsp_valid}); end
    checks++; if ({alu_fnselec, alu_a, alu_b} !== {OP_ADD, 4'd3, 4'd4}) begin errors++; $display("FAIL single_alu_in: got %h expected %h", {alu_fnselec, alu_a, alu_b}, {OP_ADD, 4'd3, 4'd4}); end
    tick();
    checks++; if ({rsp_valid, rsp_id, rsp_res, rsp_flags} !== {1'b1, 1'b0, 4'd7, 3'b000}) begin errors++; $display("FAIL single_rsp: got %h expected %h", {rsp_valid, rsp_id, rsp_res, rsp_flags}, {1'b1, 1'b0, 4'd7, 3'b000}); end
    tick();
    checks++; if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("FAIL single_return_idle: got %b expected 00", {busy, rsp_valid}); end
  endtask

  task automatic test_rsp_ready_idle();
    req_valid = 2'b00; rsp_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if ({busy, rsp_valid, req_ready} !== 4'b0000) begin errors++; $display("FAIL idle_rsp_ready: got %b expected 0000", {busy, rsp_valid, req_ready}); end
  endtask

  task automatic test_backpressure();
    req_op = {OP_ADD, OP_AND}; req_a = {4'd7, 4'd12}; req_b = {4'd1, 4'd10};
    req_valid = 2'b01; rsp_ready = 1'b0;
    tick();
    req_valid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, busy, rsp_id, req_ready, rsp_flags, rsp_res} !== {1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 4'd8}) begin
        errors++; $display("FAIL backpressure_hold[%0d]: got %h expected %h", i,
          {rsp_valid, busy, rsp_id, req_ready, rsp_flags, rsp_res}, {1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 4'd8});
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if ({busy, rsp_valid, req_ready} !== 4'b0010) begin errors++; $display("FAIL backpressure_release: got %b expected 0010", {busy, rsp_valid, req_ready}); end
  endtask

  task automatic test_overflow();
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if ({rsp_valid, rsp_id, rsp_res, rsp_flags} !== {1'b1, 1'b1, 4'd8, 3'b010}) begin errors++; $display("FAIL overflow_rsp: got %h expected %h", {rsp_valid, rsp_id, rsp_res, rsp_flags}, {1'b1, 1'b1, 4'd8, 3'b010}); end
    tick();
  endtask

  task automatic test_reset_mid_exec();
    req_op = {OP_OR, OP_SUB}; req_a = {4'd0, 4'd5}; req_b = {4'd0, 4'd2};
    req_valid = 2'b01; rsp_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_in_exec: got %b expected 1", busy); end
    rst_n = 1'b0;
    tick();
    checks++; if ({req_ready, rsp_valid, busy, alu_a} !== {2'b00, 1'b0, 1'b0, 4'd0}) begin errors++; $display("FAIL midreset_abandon: got %h expected 0", {req_ready, rsp_valid, busy, alu_a}); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midreset_reaccept: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if ({rsp_valid, rsp_id, rsp_res, rsp_flags} !== {1'b1, 1'b0, 4'd3, 3'b000}) begin errors++; $display("FAIL midreset_rsp: got %h expected %h", {rsp_valid, rsp_id, rsp_res, rsp_flags}, {1'b1, 1'b0, 4'd3, 3'b000}); end
    tick();
  endtask

  task automatic test_contention();
    logic [5:0] order;
    int cnt0, cnt1, n;
    logic exp_id;
    logic [W-1:0] exp_res;
    order = '0; cnt0 = 0; cnt1 = 0; n = 0;
    do_reset();
    req_op = {OP_XOR, OP_ADD}; req_a = {4'd5, 4'd1}; req_b = {4'd3, 4'd1};
    rsp_ready = 1'b1; req_valid = 2'b11;
    #1;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      if (rsp_valid) begin
        exp_res = rsp_id ? 4'd6 : 4'd2;
        checks++; if (rsp_res !== exp_res) begin errors++; $display("FAIL contention_res: id %0d got %0d expected %0d", rsp_id, rsp_res, exp_res); end
      end
      if (|(req_valid & req_ready)) begin
        order[n] = req_ready[1];
        if (req_ready[1]) cnt1++; else cnt0++;
        n++;
      end
      tick();
      if (cnt0 == 3) req_valid[0] = 1'b0;
      if (cnt1 == 3) req_valid[1] = 1'b0;
      #1;
    end
    checks++; if (n != 6) begin errors++; $display("FAIL contention_timeout: got %0d grants expected 6", n); end
    for (int i = 0; i < 6; i++) begin
`ifdef ALU_ARBITER_RR_EN
      exp_id = (i % 2) != 0;
`else
      exp_id = (i >= 3);
`endif
      checks++; if (order[i] !== exp_id) begin errors++; $display("FAIL contention_order[%0d]: got %0d expected %0d", i, order[i], exp_id); end
    end
    req_valid = 2'b00;
    tick(); tick(); tick();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single_op();
    test_rsp_ready_idle();
    test_backpressure();
    test_overflow();
    test_reset_mid_exec();
    test_contention();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
